// File: rtl/hci_core_load_buffer.sv
// Credit-gated load buffer in front of the HWPE wide-port interconnect: caps loads in flight plus
// buffered at DEPTH and queues the fixed-latency load responses so the streamer can stall them.
module hci_core_load_buffer #(
    parameter int unsigned DW    = 128,
    parameter int unsigned AW    = 32,
    parameter int unsigned BW    = DW / 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          in_req_i,
    output logic          in_gnt_o,
    input  logic [AW-1:0] in_add_i,
    input  logic          in_wen_i,
    input  logic [BW-1:0] in_be_i,
    input  logic [DW-1:0] in_data_i,
    output logic [DW-1:0] in_r_data_o,
    output logic          in_r_valid_o,
    input  logic          in_r_ready_i,
    output logic          out_req_o,
    input  logic          out_gnt_i,
    output logic [AW-1:0] out_add_o,
    output logic          out_wen_o,
    output logic [BW-1:0] out_be_o,
    output logic [DW-1:0] out_data_o,
    input  logic [DW-1:0] out_r_data_i,
    input  logic          out_r_valid_i,
    output logic [CW-1:0] credits_o,
    output logic          err_o
);

    localparam int unsigned  PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          allow;
    logic          any_grant, load_grant;
    logic          resp_is_load_q, grant_q;
    logic          push, pop;
    logic          fifo_empty, fifo_full;
    logic [PW:0]   wr_ptr_q, rd_ptr_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          err_q;

    // Gating uses the registered count, so a pop frees its credit only from the next cycle on.
    assign allow      = in_wen_i ? (cnt_q < CNT_MAX) : 1'b1;
    assign out_req_o  = in_req_i & allow;
    assign in_gnt_o   = out_gnt_i & allow;
    assign out_add_o  = in_add_i;
    assign out_wen_o  = in_wen_i;
    assign out_be_o   = in_be_i;
    assign out_data_o = in_data_i;

    assign any_grant  = out_req_o & out_gnt_i;
    assign load_grant = any_grant & out_wen_o;

    // Response handshake: a beat transfers on a cycle where in_r_valid_o & in_r_ready_i; once
    // raised, in_r_valid_o and in_r_data_o hold until that transfer happens.
    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                          (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push         = out_r_valid_i & resp_is_load_q;
    assign pop          = ~fifo_empty & in_r_ready_i;
    assign in_r_valid_o = ~fifo_empty;
    assign in_r_data_o  = fifo_empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];

    assign cnt_d     = cnt_q + CW'(load_grant) - CW'(pop);
    assign credits_o = cnt_q;
    assign err_o     = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            resp_is_load_q <= 1'b0;
            grant_q        <= 1'b0;
            err_q          <= 1'b0;
        end else if (clear_i) begin
            cnt_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            resp_is_load_q <= 1'b0;
            grant_q        <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            resp_is_load_q <= load_grant;
            grant_q        <= any_grant;
            err_q          <= err_q | (out_r_valid_i & ~grant_q);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Data storage needs no reset: it is only visible while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) mem_q[wr_ptr_q[PW-1:0]] <= out_r_data_i;
    end

`ifndef SYNTHESIS
    a_cnt_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CNT_MAX);
    a_no_overflow_push : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push && !clear_i) |-> (!fifo_full || pop));
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> (cnt_q != '0));
    a_resp_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (in_r_valid_o && !in_r_ready_i && !clear_i) |=> (in_r_valid_o && $stable(in_r_data_o)));
`endif

endmodule

// File: tb/tb_hci_core_load_buffer.sv
// Bench for hci_core_load_buffer: fixed-latency interconnect responder, queue-based reference
// model checked every cycle, plus directed scenarios with hand-derived expectations.
module tb_hci_core_load_buffer;

    localparam int DW    = 128;
    localparam int AW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          in_req_i = 1'b0;
    logic          in_gnt_o;
    logic [AW-1:0] in_add_i = '0;
    logic          in_wen_i = 1'b1;
    logic [BW-1:0] in_be_i = '1;
    logic [DW-1:0] in_data_i = '0;
    logic [DW-1:0] in_r_data_o;
    logic          in_r_valid_o;
    logic          in_r_ready_i = 1'b0;
    logic          out_req_o;
    logic          out_gnt_i = 1'b0;
    logic [AW-1:0] out_add_o;
    logic          out_wen_o;
    logic [BW-1:0] out_be_o;
    logic [DW-1:0] out_data_o;
    logic [DW-1:0] out_r_data_i;
    logic          out_r_valid_i;
    logic [CW-1:0] credits_o;
    logic          err_o;

    logic          rsp_valid = 1'b0;
    logic [DW-1:0] rsp_data = '0;
    logic          spur_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DW-1:0] exp_q[$];
    int            m_cnt = 0;
    logic          m_err = 1'b0;
    logic          m_prev_load = 1'b0;
    logic          m_prev_any = 1'b0;
    logic          m_allow, m_fire, m_pop;

    assign out_r_valid_i = rsp_valid | spur_valid;
    assign out_r_data_i  = rsp_data;

    hci_core_load_buffer #(.DW(DW), .AW(AW), .BW(BW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
        .in_be_i(in_be_i), .in_data_i(in_data_i), .in_r_data_o(in_r_data_o),
        .in_r_valid_o(in_r_valid_o), .in_r_ready_i(in_r_ready_i),
        .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o),
        .out_wen_o(out_wen_o), .out_be_o(out_be_o), .out_data_o(out_data_o),
        .out_r_data_i(out_r_data_i), .out_r_valid_i(out_r_valid_i),
        .credits_o(credits_o), .err_o(err_o)
    );

    // clock / reset / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // interconnect model: one response exactly one cycle after every req&gnt
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= out_req_o & out_gnt_i;
            rsp_data  <= {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // scoreboard: queue of load data owed to the streamer, credit count, sticky error
    always @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            exp_q.delete();
            m_cnt       = 0;
            m_err       = 1'b0;
            m_prev_load = 1'b0;
            m_prev_any  = 1'b0;
        end else begin
            m_allow = in_wen_i ? (m_cnt < DEPTH) : 1'b1;
            m_fire  = in_req_i & out_gnt_i & m_allow;
            m_pop   = (exp_q.size() != 0) && in_r_ready_i;

            checks++;
            if (in_gnt_o !== (out_gnt_i & m_allow) || out_req_o !== (in_req_i & m_allow)) begin
                errors++;
                $display("FAIL model_gate: gnt=%b req=%b expected gnt=%b req=%b (cnt=%0d)",
                         in_gnt_o, out_req_o, out_gnt_i & m_allow, in_req_i & m_allow, m_cnt);
            end
            checks++;
            if (credits_o !== CW'(m_cnt)) begin
                errors++;
                $display("FAIL model_credits: got %0d expected %0d", credits_o, m_cnt);
            end
            checks++;
            if (in_r_valid_o !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL model_rvalid: got %b expected %b", in_r_valid_o, exp_q.size() != 0);
            end
            checks++;
            if (err_o !== m_err) begin
                errors++;
                $display("FAIL model_err: got %b expected %b", err_o, m_err);
            end
            if (m_pop) begin
                checks++;
                if (in_r_data_o !== exp_q[0]) begin
                    errors++;
                    $display("FAIL model_rdata: got %h expected %h", in_r_data_o, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            if (out_r_valid_i) begin
                if (!m_prev_any) m_err = 1'b1;
                if (m_prev_load) exp_q.push_back(out_r_data_i);
            end
            m_cnt       = m_cnt + ((m_fire && in_wen_i) ? 1 : 0) - (m_pop ? 1 : 0);
            m_prev_load = m_fire & in_wen_i;
            m_prev_any  = m_fire;
        end
    end

    // driver: apply one cycle of inputs at the falling edge, return 1 time unit later
    task automatic drive(input logic req, input logic wen, input logic gnt, input logic rdy,
                         input logic spur, input logic clr, input logic [AW-1:0] add);
        @(negedge clk_i);
        in_req_i     = req;
        in_wen_i     = wen;
        out_gnt_i    = gnt;
        in_r_ready_i = rdy;
        spur_valid   = spur;
        clear_i      = clr;
        in_add_i     = add;
        in_be_i      = BW'($urandom);
        in_data_i    = {$urandom, $urandom, $urandom, $urandom};
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        while ((credits_o != 0 || in_r_valid_o) && n < 40) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
            n++;
        end
        checks++;
        if (credits_o !== CW'(0) || in_r_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain: credits=%0d rvalid=%b after %0d cycles, required 0/0",
                     credits_o, in_r_valid_o, n);
        end
    endtask

    task automatic test_reset();
        in_req_i  = 1'b1;
        out_gnt_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (credits_o !== CW'(0) || in_r_valid_o !== 1'b0 || err_o !== 1'b0 ||
            in_r_data_o !== '0) begin
            errors++;
            $display("FAIL reset_values: credits=%0d rvalid=%b err=%b rdata=%h, required zeros",
                     credits_o, in_r_valid_o, err_o, in_r_data_o);
        end
        @(negedge clk_i);
        in_req_i = 1'b0;
        rst_ni   = 1'b1;
    endtask

    task automatic test_single_load();
        logic [DW-1:0] d0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100);
        checks++;
        if (in_gnt_o !== 1'b1 || credits_o !== CW'(0) || out_add_o !== 32'h100) begin
            errors++;
            $display("FAIL single_t0: gnt=%b credits=%0d add=%h, required 1/0/100",
                     in_gnt_o, credits_o, out_add_o);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        d0 = out_r_data_i;
        checks++;
        if (credits_o !== CW'(1) || in_r_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_t1: credits=%0d rvalid=%b, required 1/0", credits_o, in_r_valid_o);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (credits_o !== CW'(1) || in_r_valid_o !== 1'b1 || in_r_data_o !== d0) begin
            errors++;
            $display("FAIL single_t2: credits=%0d rvalid=%b data=%h, required 1/1/%h",
                     credits_o, in_r_valid_o, in_r_data_o, d0);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (credits_o !== CW'(0) || in_r_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_t3: credits=%0d rvalid=%b, required 0/0", credits_o, in_r_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        int grants;
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AW'(32'h200 + 16 * i));
            if (in_gnt_o) grants++;
        end
        checks++;
        if (grants != DEPTH) begin
            errors++;
            $display("FAIL b2b_grants: got %0d grants, required %0d", grants, DEPTH);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300);
        checks++;
        if (credits_o !== CW'(DEPTH) || in_gnt_o !== 1'b0 || out_req_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: credits=%0d gnt=%b req=%b, required %0d/0/0",
                     credits_o, in_gnt_o, out_req_o, DEPTH);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300);
        checks++;
        if (in_r_valid_o !== 1'b1 || in_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pop_cycle: rvalid=%b gnt=%b, required 1/0", in_r_valid_o, in_gnt_o);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300);
        checks++;
        if (in_gnt_o !== 1'b1 || credits_o !== CW'(DEPTH - 1)) begin
            errors++;
            $display("FAIL b2b_resume: gnt=%b credits=%0d, required 1/%0d",
                     in_gnt_o, credits_o, DEPTH - 1);
        end
        drain();
    endtask

    task automatic test_interleaved();
        int pulses, peak;
        pulses = 0;
        peak   = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h410);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h420);
        for (int i = 0; i < 6; i++) begin
            if (in_r_valid_o) pulses++;
            if (int'(credits_o) > peak) peak = int'(credits_o);
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        end
        checks++;
        if (pulses != 1 || peak != 1) begin
            errors++;
            $display("FAIL interleaved: rvalid cycles=%0d peak credits=%0d, required 1/1",
                     pulses, peak);
        end
    endtask

    task automatic test_stores_when_full();
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AW'(32'h500 + i));
        repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, AW'(32'h600 + i));
            if (in_gnt_o !== 1'b1 || out_req_o !== 1'b1 || credits_o !== CW'(DEPTH)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stores_full: %0d store cycles not granted or credits off, required 0", bad);
        end
        drain();
    endtask

    task automatic test_spurious_err();
        repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h700);
        repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_before: err=%b, required 0", err_o);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%b, required 1", err_o);
        end
        repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (err_o !== 1'b1 || credits_o !== CW'(2)) begin
            errors++;
            $display("FAIL err_sticky: err=%b credits=%0d, required 1/2", err_o, credits_o);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (err_o !== 1'b0 || credits_o !== CW'(0) || in_r_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b credits=%0d rvalid=%b, required 0/0/0",
                     err_o, credits_o, in_r_valid_o);
        end
    endtask

    task automatic test_clear_late_response();
        int seen;
        seen = 0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h800);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
            if (in_r_valid_o || credits_o != 0 || err_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL clear_late: %0d cycles with rvalid/credits/err nonzero, required 0", seen);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0), 1'b0, 1'b0,
                  AW'($urandom));
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_back_to_back();
        test_interleaved();
        test_stores_when_full();
        test_spurious_err();
        test_clear_late_response();
        test_random();
        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hci_core_load_buffer.md
Name: hci_core_load_buffer

Overview:
Sits directly upstream of the HWPE wide-port interconnect, between an HWPE streamer's wide HCI core port and the interconnect's input. It gates load requests with a credit counter so that no more than DEPTH loads are ever in flight or buffered. It also captures the fixed one-cycle interconnect response into a FIFO, so the streamer may stall responses with r_ready. Write responses are absorbed here and never forwarded.

Parameters:
DW, 128, data width of the wide port; multiple of 32
AW, 32, address width
BW, DW/8, byte-enable width
DEPTH, 4, maximum loads outstanding plus buffered; power of two, at least 2
CW, $clog2(DEPTH+1), credit counter width (derived)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear, same effect as reset
in_req_i  in  1  streamer request
in_gnt_o  out  1  grant to streamer
in_add_i  in  AW  byte address
in_wen_i  in  1  1 = load, 0 = store (HCI convention)
in_be_i  in  BW  byte enables
in_data_i  in  DW  write data
in_r_data_o  out  DW  load response data
in_r_valid_o  out  1  load response valid
in_r_ready_i  in  1  streamer accepts response
out_req_o  out  1  request to interconnect
out_gnt_i  in  1  interconnect grant
out_add_o  out  AW  passthrough of in_add_i
out_wen_o  out  1  passthrough of in_wen_i
out_be_o  out  BW  passthrough of in_be_i
out_data_o  out  DW  passthrough of in_data_i
out_r_data_i  in  DW  interconnect response data
out_r_valid_i  in  1  interconnect response valid, exactly 1 cycle after each req&gnt (loads and stores)
credits_o  out  CW  current credit count (outstanding + buffered loads)
err_o  out  1  sticky protocol error

Behaviour:
- Reset/clear values: credit counter 0; FIFO empty; resp_is_load_q 0; in_r_valid_o 0; in_r_data_o 0; err_o 0; credits_o 0.
- clear_i has priority over all updates in its cycle. Responses returning after a clear are dropped.
- Request gating is combinational: allow = in_wen_i ? (cnt < DEPTH) : 1.
  - out_req_o = in_req_i & allow.
  - in_gnt_o = out_gnt_i & allow.
  - Stores are never gated.
- load_grant = out_req_o & out_gnt_i & out_wen_o.
- resp_is_load_q is a register set to load_grant every cycle. It marks whether the response arriving next cycle belongs to a load.
- Push: FIFO pushes out_r_data_i when out_r_valid_i & resp_is_load_q.
  - When out_r_valid_i & ~resp_is_load_q, the store response is discarded.
- Error: out_r_valid_i without a request granted in the previous cycle sets err_o.
  - err_o stays set until reset or clear.
- Pop: FIFO pops when in_r_valid_o & in_r_ready_i.
  - in_r_valid_o = FIFO not empty.
  - in_r_data_o = FIFO head, registered storage with no fall-through.
- Load-to-response latency: minimum 2 cycles from the grant edge. Grant in cycle t, interconnect r_valid in t+1, in_r_valid_o in t+2.
- Credit update: cnt_next = cnt + load_grant - pop.
  - Simultaneous grant and pop leaves cnt unchanged.
  - cnt never exceeds DEPTH, so the FIFO can never overflow.
  - Overflow is impossible by construction; assert it under non-synthesis.
- Full condition: at cnt == DEPTH, loads are held off (in_gnt_o = 0, out_req_o = 0). Stores still pass.
- Credit release: a pop in the same cycle does not re-enable a grant until the next cycle. Gating uses the registered cnt.
- FIFO pointers wrap modulo DEPTH. Occupancy is always at most cnt.
- Assertions (non-synthesis):
  - in_r_valid_o held with stable in_r_data_o until popped.
  - Push never occurs while the FIFO is full.
  - cnt is never decremented below 0.

Test Plan:
- Single load to address 0x100, out_gnt_i = 1, in_r_ready_i = 1 -> in_gnt_o at t0, out_r_valid_i at t1, in_r_valid_o high at t2 with the response data; credits_o goes 0 -> 1 -> 1 -> 0.
- Back-to-back loads with in_r_ready_i = 0 and DEPTH = 4 -> exactly 4 grants, then in_gnt_o = 0 and credits_o = 4; releasing ready drains responses in order with data D0..D3; granting resumes one cycle after the first pop.
- Interleaved store/load/store with in_r_ready_i = 1 -> only one in_r_valid_o pulse (the load's data); credits_o peaks at 1; store responses are not forwarded.
- Stores issued while credits_o = DEPTH -> stores are granted every cycle and credits_o stays at DEPTH.
- Spurious out_r_valid_i with no prior grant -> err_o = 1 next cycle and stays set; clear_i pulse -> err_o = 0, credits_o = 0, FIFO empty.
- Assert clear_i one cycle after a load grant -> the late response is dropped, in_r_valid_o stays 0, and credits_o = 0.
